// File: rtl/PARAMS_BN254_d0.sv
// Shared BN254 datapath parameters for the PE chain and its downstream stages.
package PARAMS_BN254_d0;

    localparam int unsigned K     = 17;
    localparam int unsigned PE_SW = 48;

    typedef logic [K-1:0] digit_t;

    // Flush digits needed to drain a carry of PE_SW+1-k bits in k-bit digits.
    function automatic int unsigned carry_nfl(input int unsigned k);
        int unsigned cw;
        cw = PE_SW + 1 - k;
        return (cw + k - 1) / k;
    endfunction

endpackage

// File: rtl/pe_carry_normalizer_pkg.sv
// Local types for the carry normalizer.
package pe_carry_normalizer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } norm_state_t;

endpackage

// File: rtl/pe_carry_normalizer_if.sv
// Word-in / digit-out stream bundle of the carry normalizer.
interface pe_carry_normalizer_if #(
    parameter int unsigned K = PARAMS_BN254_d0::K
);
    localparam int unsigned SW = PARAMS_BN254_d0::PE_SW;

    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] in_s;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [K-1:0]  out_digit;
    logic          out_last;
    logic          busy;

    modport master (
        output in_valid, in_s, in_last, out_ready,
        input  in_ready, out_valid, out_digit, out_last, busy
    );

    modport slave (
        input  in_valid, in_s, in_last, out_ready,
        output in_ready, out_valid, out_digit, out_last, busy
    );
endinterface

// File: rtl/pe_norm_outreg.sv
// One-entry valid/ready output register; holds its payload until it is taken.
module pe_norm_outreg #(
    parameter int unsigned W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_digit,
    input  logic         load_last,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_digit,
    output logic         out_last
);

    // Caller only loads when the slot is empty or being drained this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_digit <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_digit <= load_digit;
            out_last  <= load_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/pe_carry_normalizer.sv
// Turns the PE chain's redundant 48-bit column sums into exact K-bit digits,
// flushing the residual carry after the last word of each operand.
module pe_carry_normalizer
    import pe_carry_normalizer_pkg::*;
#(
    parameter int unsigned K = PARAMS_BN254_d0::K
) (
    input logic                  clk,
    input logic                  rst_n,
    pe_carry_normalizer_if.slave bus
);

    localparam int unsigned SW  = PARAMS_BN254_d0::PE_SW;
    localparam int unsigned AW  = SW + 1;
    localparam int unsigned CW  = SW + 1 - K;
    localparam int unsigned NFL = PARAMS_BN254_d0::carry_nfl(K);
    localparam int unsigned FCW = (NFL > 1) ? $clog2(NFL) : 1;

    norm_state_t    state;
    logic [CW-1:0]  carry;
    logic [FCW-1:0] fc;
    logic           busy_q;

    logic [AW-1:0]  acc_c;
    logic [CW-1:0]  carry_next_c;
    logic           slot_free_c;
    logic           in_ready_c;
    logic           in_fire_c;
    logic           out_fire_c;
    logic           last_flush_c;
    logic           load_c;
    logic [K-1:0]   load_digit_c;
    logic           load_last_c;

    logic           ov;
    logic [K-1:0]   od;
    logic           ol;

    // Datapath and load steering; carry < 2^CW keeps acc inside SW+1 bits.
    always_comb begin
        acc_c        = AW'(bus.in_s) + AW'(carry);
        carry_next_c = CW'(acc_c >> K);
        slot_free_c  = !ov || bus.out_ready;
        out_fire_c   = ov && bus.out_ready;
        last_flush_c = (fc == FCW'(NFL - 1));
        in_ready_c   = (state == ST_RUN) && slot_free_c;
        in_fire_c    = bus.in_valid && in_ready_c;

        load_c       = 1'b0;
        load_digit_c = acc_c[K-1:0];
        load_last_c  = 1'b0;
        case (state)
            ST_RUN: begin
                load_c = in_fire_c;
            end
            ST_FLUSH: begin
                load_c       = slot_free_c;
                load_digit_c = carry[K-1:0];
                load_last_c  = last_flush_c;
            end
            default: begin
                load_c = 1'b0;
            end
        endcase
    end

    // Operand sequencing: accumulate words, drain carry, wait for last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_RUN;
            carry  <= '0;
            fc     <= '0;
            busy_q <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (in_fire_c) begin
                        carry  <= carry_next_c;
                        busy_q <= 1'b1;
                        if (bus.in_last) begin
                            state <= ST_FLUSH;
                            fc    <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (slot_free_c) begin
                        carry <= carry >> K;
                        fc    <= fc + FCW'(1);
                        if (last_flush_c) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_fire_c && ol) begin
                        state  <= ST_RUN;
                        carry  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    pe_norm_outreg #(
        .W (K)
    ) u_outreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load_c),
        .load_digit (load_digit_c),
        .load_last  (load_last_c),
        .out_ready  (bus.out_ready),
        .out_valid  (ov),
        .out_digit  (od),
        .out_last   (ol)
    );

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = ov;
    assign bus.out_digit = od;
    assign bus.out_last  = ol;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_pe_carry_normalizer.sv
// Self-checking bench for pe_carry_normalizer: table vectors, random operands
// against a big-integer reference, back-to-back and mid-flush reset sequences.
module tb_pe_carry_normalizer;

    localparam int unsigned K   = PARAMS_BN254_d0::K;
    localparam int unsigned SW  = PARAMS_BN254_d0::PE_SW;
    localparam int unsigned NFL = PARAMS_BN254_d0::carry_nfl(K);

    typedef logic [SW-1:0] word_t;
    typedef PARAMS_BN254_d0::digit_t digit_t;
    typedef logic [511:0] big_t;

    typedef struct {
        int                  n;
        logic [7:0][SW-1:0]  w;
        int                  nd;
        logic [9:0][K-1:0]   d;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    pe_carry_normalizer_if #(.K(K)) bus();

    pe_carry_normalizer #(.K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     rdy_mode = 0;
    digit_t got_d[$];
    bit     got_l[$];
    int     got_c[$];
    digit_t exp_d[$];
    bit     exp_l[$];
    vec_t   tbl[5];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // out_ready driver: 0 high, 1 toggling, 2 random, otherwise low
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ~bus.out_ready;
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
        end
    end

    // Output monitor: collects transfers and checks stall behaviour.
    initial begin
        bit     stall_prev;
        digit_t stall_d;
        bit     stall_l;
        stall_prev = 1'b0;
        stall_d    = '0;
        stall_l    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (stall_prev) begin
                    check("stall_hold_valid", 64'(bus.out_valid), 64'd1);
                    check("stall_hold_digit", 64'(bus.out_digit), 64'(stall_d));
                    check("stall_hold_last", 64'(bus.out_last), 64'(stall_l));
                end
                if (bus.out_valid && !bus.out_ready) begin
                    check("in_ready_during_stall", 64'(bus.in_ready), 64'd0);
                    stall_prev = 1'b1;
                    stall_d    = bus.out_digit;
                    stall_l    = bus.out_last;
                end else begin
                    stall_prev = 1'b0;
                end
                if (bus.out_valid && bus.out_ready) begin
                    got_d.push_back(bus.out_digit);
                    got_l.push_back(bus.out_last);
                    got_c.push_back(cyc);
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    function automatic big_t sum_words(input word_t w[$]);
        big_t s;
        s = '0;
        foreach (w[i]) s = s + (big_t'(w[i]) << (K * i));
        return s;
    endfunction

    // Reference: radix-2^K digits of sum(s_i * 2^(K*i)), N+NFL digits.
    task automatic model_append(input word_t w[$]);
        big_t s;
        int   nd;
        s  = sum_words(w);
        nd = w.size() + int'(NFL);
        for (int j = 0; j < nd; j++) begin
            exp_d.push_back(digit_t'(s >> (K * j)));
            exp_l.push_back(j == nd - 1);
        end
    endtask

    // Entered and left at posedge+1; returns the cycle of the first word's acceptance.
    task automatic send_words(input word_t w[$], input bit gaps, output int first_cyc);
        bit fire;
        int t;
        first_cyc = -1;
        for (int i = 0; i < w.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            bus.in_valid = 1'b1;
            bus.in_s     = w[i];
            bus.in_last  = (i == w.size() - 1);
            t = 0;
            do begin
                @(negedge clk);
                fire = bus.in_valid && bus.in_ready;
                if (fire && i == 0) first_cyc = cyc;
                @(posedge clk);
                #1;
                t++;
            end while (!fire && t < 500);
            if (!fire) begin
                check("in_accept_timeout", 64'd0, 64'd1);
                break;
            end
            if (i == 0) check("busy_after_first_word", 64'(bus.busy), 64'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_and_compare(input string nm);
        int t;
        t = 0;
        while (got_d.size() < exp_d.size() && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({nm, "_digit_count"}, 64'(got_d.size()), 64'(exp_d.size()));
        for (int j = 0; j < exp_d.size() && j < got_d.size(); j++) begin
            check($sformatf("%s_digit%0d", nm, j), 64'(got_d[j]), 64'(exp_d[j]));
            check($sformatf("%s_last%0d", nm, j), 64'(got_l[j]), 64'(exp_l[j]));
        end
        check({nm, "_busy_idle"}, 64'(bus.busy), 64'd0);
        check({nm, "_valid_idle"}, 64'(bus.out_valid), 64'd0);
    endtask

    // A table (td non-empty) takes precedence over the reference model.
    task automatic run_op(input word_t w[$], input digit_t td[$], input string nm, input bit gaps);
        int fc;
        got_d.delete(); got_l.delete(); got_c.delete();
        exp_d.delete(); exp_l.delete();
        model_append(w);
        if (td.size() != 0) begin
            exp_d = td;
            exp_l.delete();
            for (int j = 0; j < td.size(); j++) exp_l.push_back(j == td.size() - 1);
        end
        send_words(w, gaps, fc);
        wait_and_compare(nm);
    endtask

    initial begin
        word_t  w[$];
        word_t  wb[$];
        digit_t td[$];
        big_t   recon;
        int     fa, fb, idx;

        // Vector table (K=17, NFL=2); nd == 0 means expected digits come from the model.
        foreach (tbl[i]) begin tbl[i].n = 0; tbl[i].w = '0; tbl[i].nd = 0; tbl[i].d = '0; end
        tbl[0].n = 1; tbl[0].w[0] = 48'h0000_0003_FFFF;
        tbl[0].nd = 3; tbl[0].d[0] = 17'h1FFFF; tbl[0].d[1] = 17'h00001; tbl[0].d[2] = 17'h0;
        tbl[1].n = 2; tbl[1].w[0] = 48'h1FFFF; tbl[1].w[1] = 48'h00001;
        tbl[1].nd = 4; tbl[1].d[0] = 17'h1FFFF; tbl[1].d[1] = 17'h00001;
        tbl[2].n = 2; tbl[2].w[0] = 48'h3FFFF; tbl[2].w[1] = 48'h1FFFF;
        tbl[2].nd = 4; tbl[2].d[0] = 17'h1FFFF; tbl[2].d[1] = 17'h0; tbl[2].d[2] = 17'h00001;
        tbl[3].n = 1; tbl[3].w[0] = 48'h5;
        tbl[3].nd = 3; tbl[3].d[0] = 17'h5;
        tbl[4].n = 8;
        for (int i = 0; i < 8; i++) tbl[4].w[i] = 48'hFFFF_FFFF_FFFF;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_s      = '0;
        bus.in_last   = 1'b0;
        #12;
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_out_digit", 64'(bus.out_digit), 64'd0);
        check("reset_out_last", 64'(bus.out_last), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors: first with free-flowing output, then under 1010 backpressure.
        for (int mode = 0; mode < 2; mode++) begin
            rdy_mode = mode;
            for (int v = 0; v < 5; v++) begin
                w.delete(); td.delete();
                for (int i = 0; i < tbl[v].n; i++) w.push_back(tbl[v].w[i]);
                for (int j = 0; j < tbl[v].nd; j++) td.push_back(tbl[v].d[j]);
                run_op(w, td, $sformatf("tbl%0d_m%0d", v, mode), mode == 1);
            end
        end

        // Max-stress reassembly against the exact integer sum.
        rdy_mode = 0;
        w.delete(); td.delete();
        for (int i = 0; i < 8; i++) w.push_back(48'hFFFF_FFFF_FFFF);
        run_op(w, td, "stress", 1'b0);
        recon = '0;
        foreach (got_d[j]) recon = recon | (big_t'(got_d[j]) << (K * j));
        check("stress_reassembled", 64'(recon == sum_words(w)), 64'd1);

        // Random operands, random backpressure and input gaps.
        for (int r = 0; r < 40; r++) begin
            int n;
            rdy_mode = int'($urandom_range(0, 2));
            n = int'($urandom_range(1, 8));
            w.delete(); td.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       w.push_back(48'hFFFF_FFFF_FFFF);
                    1:       w.push_back(48'h0);
                    default: w.push_back(word_t'({$urandom, $urandom}));
                endcase
            end
            run_op(w, td, $sformatf("rnd%0d", r), 1'(r[0]));
        end

        // Back-to-back: B presented during A's flush, accepted right after A's out_last.
        rdy_mode = 0;
        w.delete(); wb.delete();
        for (int i = 0; i < 3; i++) w.push_back(48'hFFFF_FFFF_FFFF);
        wb.push_back(48'h5);
        wb.push_back(48'h7);
        got_d.delete(); got_l.delete(); got_c.delete();
        exp_d.delete(); exp_l.delete();
        model_append(w);
        model_append(wb);
        send_words(w, 1'b0, fa);
        send_words(wb, 1'b0, fb);
        wait_and_compare("b2b");
        idx = w.size() + int'(NFL) - 1;
        if (got_c.size() > idx)
            check("b2b_accept_cycle", 64'(fb), 64'(got_c[idx] + 1));
        else
            check("b2b_a_last_seen", 64'(got_c.size()), 64'(idx + 1));

        // Reset while a flush digit is stalled.
        rdy_mode = 3;
        repeat (2) @(posedge clk);
        #1;
        w.delete();
        w.push_back(48'h3FFFF);
        send_words(w, 1'b0, fa);
        repeat (2) @(posedge clk);
        #1;
        check("preflush_busy", 64'(bus.busy), 64'd1);
        check("preflush_out_valid", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midflush_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midflush_rst_busy", 64'(bus.busy), 64'd0);
        check("midflush_rst_out_last", 64'(bus.out_last), 64'd0);
        check("midflush_rst_out_digit", 64'(bus.out_digit), 64'd0);
        check("midflush_rst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        w.delete(); td.delete();
        w.push_back(48'h5);
        td.push_back(17'h5); td.push_back(17'h0); td.push_back(17'h0);
        run_op(w, td, "post_reset", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pe_carry_normalizer.md
Name: pe_carry_normalizer

Overview:
- Downstream stage of the PE / PE_24 multiply-accumulate chain.
- Consumes the stream of 48-bit redundant column sums (out_s) emitted one word per cycle, least significant first.
- Propagates carries across words and emits a normalized stream of K-bit digits.
- After the last input word, flushes the residual carry as extra digits, so the output is the exact radix-2^K representation of sum(s_i * 2^(K*i)).

Parameters:
- K, PARAMS_BN254_d0::K, digit width in bits (1..24).
- SW, 48, input word width (DSP P width).
- CW, SW+1-K, carry register width; derived, not overridable.
- NFL, ceil(CW/K), number of flush digits emitted after in_last.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, in_s/in_last valid.
- in_ready, out, 1, block accepts input this cycle.
- in_s, in, SW, unsigned column sum from PE chain.
- in_last, in, 1, marks final word of an operand.
- out_valid, out, 1, out_digit valid.
- out_ready, in, 1, consumer accepts digit.
- out_digit, out, K, normalized digit.
- out_last, out, 1, final digit of operand (last flush digit).
- busy, out, 1, high from first accepted word until final digit accepted.

Behaviour:
- Reset: clk single domain; rst_n asynchronous assert, synchronous deassert expected from the top level. All outputs reset to 0: out_valid=0, out_digit=0, out_last=0, busy=0, and the internal carry is 0. in_ready is combinational and therefore reads 1 in reset. State goes to RUN.
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_digit and out_last hold stable while out_valid & !out_ready.
- Arithmetic:
  - acc = in_s + carry, SW+1 bits.
  - Digit = acc[K-1:0]; carry_next = acc >> K.
  - carry < 2^CW holds invariantly (overflow is impossible), so no saturation logic is required.
- States:
  - RUN:
    - in_ready = !out_valid | out_ready.
    - On input transfer: register digit; out_valid <= 1; carry <= carry_next; busy <= 1.
    - If in_last: go to FLUSH with flush counter fc = 0.
  - FLUSH:
    - in_ready = 0.
    - When the output slot is free (!out_valid | out_ready): emit carry[K-1:0], carry <= carry >> K, fc++.
    - On fc == NFL-1, assert out_last with that digit and go to DRAIN.
  - DRAIN:
    - in_ready = 0.
    - When the out_last digit transfers: out_valid <= 0, carry <= 0, busy <= 0, go to RUN.
- Latency and throughput:
  - 1 cycle from input transfer to out_valid.
  - Throughput 1 digit/cycle with out_ready held high.
  - An operand of N words produces exactly N+NFL digits, and flush digits are always emitted even if zero.
- Back-to-back operands: the next operand is accepted in the cycle after the out_last transfer. There is no bubble beyond the DRAIN return cycle.
- Boundary cases:
  - out_ready low: the pipeline stalls and in_ready drops (no loss, no duplication).
  - in_valid without in_ready: no state change.
  - Single-word operand (first word carries in_last): legal.
  - rst_n asserted mid-operand: carry is discarded and all outputs go to 0 immediately (asynchronously).

Decomposition:
- Use K from PARAMS_BN254_d0.
- Add to that package: PE_SW=48 and function carry_nfl(K) returning NFL, shared with the upstream word sequencer and the scoreboard.
- Add typedef digit_t = logic [K-1:0].
- One natural sub-module, pe_norm_outreg: a one-entry output register with valid/ready, used for the RUN digit and the flush digits alike.
- The FSM, carry register and adder stay in the top module.

Test Plan (K=17, CW=32, NFL=2):
- Single word in_s=0x0000_0003_FFFF, in_last=1, out_ready=1 -> digits 0x1FFFF, 0x00001, 0x00000; out_last on 3rd; busy falls after.
- Words 0x1FFFF, 0x00001 (last) -> digits 0x1FFFF, 0x00001, 0, 0 (no carry). Then 0x3FFFF, 0x1FFFF (last) -> 0x1FFFF, 0x00000, 0x00001, 0.
- Max stress: 8 words of 0xFFFF_FFFF_FFFF, last on 8th -> 10 digits; reassembled value equals reference sum(s_i<<17i); carry never exceeds 32 bits.
- Backpressure: out_ready toggles 1010… and in_valid is random -> digit sequence identical to the no-stall run; in_ready=0 whenever out_valid&!out_ready; digits held stable.
- Back-to-back: operand B's first word is presented during operand A's flush -> not accepted until the cycle after A's out_last transfer; B's digits are unaffected by A's carry.
- Reset mid-flush: rst_n low during FLUSH -> out_valid=0, busy=0 immediately. After release, a new single word 0x5 yields 0x5, 0, 0.
